// File: rtl/vga_timing_gen.sv
// Raster timing generator: 12-bit column/line counters with registered video_on, sync and frame_start decodes.
// Optional VGA_FRAME_COUNT_EN adds a 16-bit count of completed frames.
module vga_timing_gen #(
    parameter int H_ACTIVE = 1280,
    parameter int H_FP     = 110,
    parameter int H_SYNC   = 40,
    parameter int H_BP     = 220,
    parameter int V_ACTIVE = 720,
    parameter int V_FP     = 5,
    parameter int V_SYNC   = 5,
    parameter int V_BP     = 20,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic        run,
    output logic [11:0] pixel_x,
    output logic [11:0] pixel_y,
    output logic        video_on,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start,
    output logic        busy,
`ifdef VGA_FRAME_COUNT_EN
    output logic [15:0] frame_count,
`endif
    output int          width,
    output int          height
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Decode thresholds are 13 bits so a 4096-wide raster cannot alias to 0.
    localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
    localparam logic [12:0] H_ACT  = 13'(H_ACTIVE);
    localparam logic [12:0] HS_BEG = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] HS_END = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] V_ACT  = 13'(V_ACTIVE);
    localparam logic [12:0] VS_BEG = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] VS_END = 13'(V_ACTIVE + V_FP + V_SYNC);

    generate
        if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_size_check
            $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 4096");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state_q, state_d;
    logic [11:0] x_q, x_d, y_q, y_d;
    logic        video_on_q, video_on_d;
    logic        hsync_q, hsync_d;
    logic        vsync_q, vsync_d;
    logic        frame_start_q, frame_start_d;
    logic        frame_wrap;
    logic        in_run;
`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] frame_count_q, frame_count_d;
`endif

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        frame_wrap = 1'b0;
        case (state_q)
            IDLE: begin
                // Position is already (0,0) in IDLE, so only the state moves.
                if (ce && run) state_d = RUN;
            end
            RUN: begin
                if (ce) begin
                    if (x_q == H_LAST) begin
                        x_d = '0;
                        if (y_q == V_LAST) begin
                            y_d        = '0;
                            frame_wrap = 1'b1;
                            if (!run) state_d = IDLE;
                        end else begin
                            y_d = y_q + 12'd1;
                        end
                    end else begin
                        x_d = x_q + 12'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        in_run        = (state_d == RUN);
        video_on_d    = in_run && ({1'b0, x_d} < H_ACT) && ({1'b0, y_d} < V_ACT);
        hsync_d       = (in_run && ({1'b0, x_d} >= HS_BEG) && ({1'b0, x_d} < HS_END))
                        ? SYNC_POL : ~SYNC_POL;
        vsync_d       = (in_run && ({1'b0, y_d} >= VS_BEG) && ({1'b0, y_d} < VS_END))
                        ? SYNC_POL : ~SYNC_POL;
        frame_start_d = in_run && ((state_q == IDLE) || frame_wrap);
`ifdef VGA_FRAME_COUNT_EN
        // The launch pulse out of IDLE is not a completed frame; only wraps count.
        frame_count_d = frame_count_q;
        if (!in_run)         frame_count_d = '0;
        else if (frame_wrap) frame_count_d = frame_count_q + 16'd1;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            x_q           <= '0;
            y_q           <= '0;
            video_on_q    <= 1'b0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            frame_start_q <= 1'b0;
`ifdef VGA_FRAME_COUNT_EN
            frame_count_q <= '0;
`endif
        end else begin
            state_q       <= state_d;
            x_q           <= x_d;
            y_q           <= y_d;
            video_on_q    <= video_on_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
`ifdef VGA_FRAME_COUNT_EN
            frame_count_q <= frame_count_d;
`endif
        end
    end

    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign video_on    = video_on_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;
    assign busy        = (state_q == RUN);
`ifdef VGA_FRAME_COUNT_EN
    assign frame_count = frame_count_q;
`endif
    assign width       = H_ACTIVE;
    assign height      = V_ACTIVE;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: u_a has 720p line timing with an 8-line frame; u_b is a 16x10 raster with active-low syncs.
module tb_vga_timing_gen;
    logic        clk = 1'b0;
    logic        reset;
    logic        ce_a, run_a, ce_b, run_b;
    logic [11:0] x_a, y_a, x_b, y_b;
    logic        von_a, hs_a, vs_a, fs_a, busy_a;
    logic        von_b, hs_b, vs_b, fs_b, busy_b;
    int          width_a, height_a, width_b, height_b;
`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] fc_a, fc_b;
`endif
    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vga_timing_gen #(
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b1)
    ) u_a (
        .clk(clk), .reset(reset), .ce(ce_a), .run(run_a),
        .pixel_x(x_a), .pixel_y(y_a), .video_on(von_a), .hsync(hs_a), .vsync(vs_a),
        .frame_start(fs_a), .busy(busy_a),
`ifdef VGA_FRAME_COUNT_EN
        .frame_count(fc_a),
`endif
        .width(width_a), .height(height_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1), .SYNC_POL(1'b0)
    ) u_b (
        .clk(clk), .reset(reset), .ce(ce_b), .run(run_b),
        .pixel_x(x_b), .pixel_y(y_b), .video_on(von_b), .hsync(hs_b), .vsync(vs_b),
        .frame_start(fs_b), .busy(busy_b),
`ifdef VGA_FRAME_COUNT_EN
        .frame_count(fc_b),
`endif
        .width(width_b), .height(height_b)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; ce_a = 1'b1; run_a = 1'b1; ce_b = 1'b1; run_b = 1'b0;
        tick(3);
        chk("rst_x_a", x_a, 0);        chk("rst_y_a", y_a, 0);
        chk("rst_von_a", von_a, 0);    chk("rst_hs_a", hs_a, 0);
        chk("rst_vs_a", vs_a, 0);      chk("rst_fs_a", fs_a, 0);
        chk("rst_busy_a", busy_a, 0);  chk("rst_hs_b_idle_high", hs_b, 1);
        chk("rst_vs_b_idle_high", vs_b, 1);
        chk("width_a", width_a, 1280); chk("height_a", height_a, 4);

        reset = 1'b1;
        tick(1); t0 = cyc;
        chk("start_fs", fs_a, 1);  chk("start_von", von_a, 1);
        chk("start_busy", busy_a, 1); chk("start_x", x_a, 0); chk("start_y", y_a, 0);
        chk("b_idle_no_run", busy_b, 0);
        tick(1);    chk("fs_one_cycle", fs_a, 0); chk("x_step", x_a, 1);
        tick(1278); chk("x_1279", x_a, 1279); chk("von_1279", von_a, 1);
        tick(1);    chk("x_1280", x_a, 1280); chk("von_1280", von_a, 0);
        tick(109);  chk("hs_1389", hs_a, 0);
        tick(1);    chk("hs_1390", hs_a, 1);
        tick(39);   chk("x_1429", x_a, 1429); chk("hs_1429", hs_a, 1);
        tick(1);    chk("hs_1430", hs_a, 0);
        tick(219);  chk("x_1649", x_a, 1649); chk("y_line0", y_a, 0);
        tick(1);    chk("x_wrap", x_a, 0); chk("y_line1", y_a, 1); chk("von_line1", von_a, 1);
        tick(4950); chk("y_4", y_a, 4); chk("vs_line4", vs_a, 0); chk("von_line4", von_a, 0);
        tick(1650); chk("y_5", y_a, 5); chk("vs_line5", vs_a, 1);
        tick(3299); chk("x_end_l6", x_a, 1649); chk("y_6", y_a, 6); chk("vs_line6_end", vs_a, 1);
        tick(1);    chk("y_7", y_a, 7); chk("vs_line7", vs_a, 0);
        tick(1649); chk("fs_before_wrap", fs_a, 0);
        tick(1);    chk("fs_frame2", fs_a, 1); chk("frame_x", x_a, 0); chk("frame_y", y_a, 0);
        chk("frame_period", cyc - t0, 13200);

        ce_a = 1'b0;
        tick(1); chk("ce0_fs_drops", fs_a, 0); chk("ce0_x_hold", x_a, 0);
        tick(1); chk("ce0_x_hold2", x_a, 0);
        ce_a = 1'b1; tick(1); chk("ce1_x", x_a, 1);
        ce_a = 1'b0; tick(2); chk("ce00_x", x_a, 1);
        ce_a = 1'b1; tick(1); chk("ce1_x2", x_a, 2);

        run_b = 1'b1;
        tick(1);  chk("b_fs", fs_b, 1); chk("b_busy", busy_b, 1);
        chk("b_von", von_b, 1); chk("b_hs_inactive", hs_b, 1);
`ifdef VGA_FRAME_COUNT_EN
        chk("fc_first", fc_b, 0);
`endif
        tick(10); chk("b_x10", x_b, 10); chk("b_hs10", hs_b, 0); chk("b_von10", von_b, 0);
        tick(2);  chk("b_hs12", hs_b, 0);
        tick(1);  chk("b_hs13", hs_b, 1);
        run_b = 1'b0;
        tick(114); chk("b_x_l7", x_b, 15); chk("b_y7", y_b, 7); chk("b_vs7", vs_b, 0);
        chk("b_busy_midstop", busy_b, 1);
        tick(32); chk("b_last_x", x_b, 15); chk("b_last_y", y_b, 9);
        chk("b_vs9", vs_b, 1); chk("b_busy_last", busy_b, 1);
        tick(1);  chk("stop_busy", busy_b, 0); chk("stop_x", x_b, 0); chk("stop_y", y_b, 0);
        chk("stop_von", von_b, 0); chk("stop_fs", fs_b, 0); chk("stop_hs", hs_b, 1);
        tick(3);  chk("stay_idle", busy_b, 0);

        run_b = 1'b1;
        tick(1);  chk("restart_fs", fs_b, 1);
        run_b = 1'b0; tick(50);
        run_b = 1'b1; tick(110);
        chk("cancel_stop_fs", fs_b, 1); chk("cancel_stop_busy", busy_b, 1);
`ifdef VGA_FRAME_COUNT_EN
        chk("fc_second", fc_b, 1);
`endif
        tick(160); chk("fs_third", fs_b, 1);
`ifdef VGA_FRAME_COUNT_EN
        chk("fc_third", fc_b, 2);
`endif
        run_b = 1'b0;
        tick(160); chk("stop2_busy", busy_b, 0);
`ifdef VGA_FRAME_COUNT_EN
        chk("fc_idle_clear", fc_b, 0);
`endif
        run_b = 1'b1;
        tick(1);  chk("restart2_fs", fs_b, 1);
`ifdef VGA_FRAME_COUNT_EN
        chk("fc_restart", fc_b, 0);
`endif

        tick(37); chk("pre_rst_x", x_b, 5); chk("pre_rst_y", y_b, 2);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy_b", busy_b, 0); chk("arst_x_b", x_b, 0); chk("arst_y_b", y_b, 0);
        chk("arst_hs_b", hs_b, 1);     chk("arst_von_b", von_b, 0);
        chk("arst_busy_a", busy_a, 0); chk("arst_x_a", x_a, 0); chk("arst_hs_a", hs_a, 0);
        @(negedge clk);
        chk("arst_hold", busy_a, 0);
        reset = 1'b1;
        tick(1);  chk("post_rst_fs", fs_a, 1); chk("post_rst_busy", busy_a, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
